// File: rtl/superscalar_decode_pkg.sv
// Shared types for the superscalar decode stage: opcodes, control bus,
// per-lane decode record, resource-need record and the stage state names.
package superscalar_decode_pkg;

   // Width of immediates and PCs carried in a decoded lane.
   localparam int PKG_XLEN = 32;

   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   // Control word handed to rename/dispatch (first field is the MSB).
   typedef struct packed {
      logic       rf_write_en;
      logic       mem_read_en;
      logic       mem_write_en;
      logic       alu_src_imm;
      logic       is_branch;
      logic       is_jump;
      logic [3:0] alu_op;
   } control_signal_bus;

   localparam int CTRL_W = $bits(control_signal_bus);

   typedef struct packed {
      control_signal_bus     ctrl;
      logic [PKG_XLEN-1:0]   imm;
      logic [PKG_XLEN-1:0]   pc;
      logic                  illegal;
   } decode_lane_t;

   // Extra queue entries an instruction needs beyond its ROB slot.
   typedef struct packed {
      logic ld;
      logic st;
   } res_need_t;

   typedef enum logic {
      IDLE    = 1'b0,
      PARTIAL = 1'b1
   } dec_state_t;

   function automatic logic [3:0] popcount8(input logic [7:0] v);
      logic [3:0] n;
      n = '0;
      for (int i = 0; i < 8; i++) begin
         n = n + {3'b000, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/decode_alloc_select.sv
// In-order prefix fit: walks remaining lanes in ascending index, accumulating
// ROB/LDQ/STQ need, and issues lanes until the first one that does not fit.
module decode_alloc_select #(
   parameter int WIDTH = 2,
   parameter int CNT_W = 6
) (
   input  logic [WIDTH-1:0] remaining,
   input  logic [WIDTH-1:0] is_load,
   input  logic [WIDTH-1:0] is_store,
   input  logic [CNT_W:0]   rob_avail,
   input  logic [CNT_W:0]   ldq_avail,
   input  logic [CNT_W:0]   stq_avail,
   output logic [WIDTH-1:0] issue_mask
);

   // Cumulative need up to and including each lane; separate elements per
   // lane keep the carry chain free of self-referencing vectors.
   logic [CNT_W:0]   cum_rob [WIDTH+1];
   logic [CNT_W:0]   cum_ldq [WIDTH+1];
   logic [CNT_W:0]   cum_stq [WIDTH+1];
   logic             still_ok [WIDTH+1];
   logic [WIDTH-1:0] fits;

   assign cum_rob[0]  = '0;
   assign cum_ldq[0]  = '0;
   assign cum_stq[0]  = '0;
   assign still_ok[0] = 1'b1;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_lane
         assign cum_rob[gi+1] = cum_rob[gi] + {{CNT_W{1'b0}}, remaining[gi]};
         assign cum_ldq[gi+1] = cum_ldq[gi] + {{CNT_W{1'b0}}, remaining[gi] & is_load[gi]};
         assign cum_stq[gi+1] = cum_stq[gi] + {{CNT_W{1'b0}}, remaining[gi] & is_store[gi]};
         assign fits[gi]      = (cum_rob[gi+1] <= rob_avail) &&
                                (cum_ldq[gi+1] <= ldq_avail) &&
                                (cum_stq[gi+1] <= stq_avail);
         assign issue_mask[gi]  = remaining[gi] & still_ok[gi] & fits[gi];
         // Once a remaining lane fails, every later lane is blocked.
         assign still_ok[gi+1]  = still_ok[gi] & (~remaining[gi] | fits[gi]);
      end
   endgenerate

endmodule

// File: rtl/instruction_decode.sv
// Single-instruction RV32I-style decoder: control word, immediate, illegal flag
// and queue needs. Unknown opcodes produce an all-zero control word.
module instruction_decode
   import superscalar_decode_pkg::*;
(
   input  logic [31:0]          instr,
   input  logic [PKG_XLEN-1:0]  pc,
   output decode_lane_t         dec,
   output res_need_t            need
);

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] i_imm;
   logic [31:0] s_imm;
   logic [31:0] b_imm;
   logic [31:0] u_imm;
   logic [31:0] j_imm;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign i_imm  = {{20{instr[31]}}, instr[31:20]};
   assign s_imm  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
   assign b_imm  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
   assign u_imm  = {instr[31:12], 12'h000};
   assign j_imm  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

   // Opcode decode; queue needs follow the memory enables so illegal ops need ROB only.
   always_comb begin
      dec     = '0;
      dec.pc  = pc;
      unique case (opcode)
         OPC_LOAD: begin
            dec.ctrl.rf_write_en = 1'b1;
            dec.ctrl.mem_read_en = 1'b1;
            dec.ctrl.alu_src_imm = 1'b1;
            dec.imm              = i_imm;
         end
         OPC_STORE: begin
            dec.ctrl.mem_write_en = 1'b1;
            dec.ctrl.alu_src_imm  = 1'b1;
            dec.imm               = s_imm;
         end
         OPC_OP_IMM: begin
            dec.ctrl.rf_write_en = 1'b1;
            dec.ctrl.alu_src_imm = 1'b1;
            dec.ctrl.alu_op      = {(funct3 == 3'b101) ? instr[30] : 1'b0, funct3};
            dec.imm              = i_imm;
         end
         OPC_OP: begin
            dec.ctrl.rf_write_en = 1'b1;
            dec.ctrl.alu_op      = {instr[30], funct3};
         end
         OPC_LUI, OPC_AUIPC: begin
            dec.ctrl.rf_write_en = 1'b1;
            dec.ctrl.alu_src_imm = 1'b1;
            dec.imm              = u_imm;
         end
         OPC_JAL: begin
            dec.ctrl.rf_write_en = 1'b1;
            dec.ctrl.is_jump     = 1'b1;
            dec.imm              = j_imm;
         end
         OPC_JALR: begin
            dec.ctrl.rf_write_en = 1'b1;
            dec.ctrl.is_jump     = 1'b1;
            dec.ctrl.alu_src_imm = 1'b1;
            dec.imm              = i_imm;
         end
         OPC_BRANCH: begin
            dec.ctrl.is_branch = 1'b1;
            dec.ctrl.alu_op    = {1'b0, funct3};
            dec.imm            = b_imm;
         end
         OPC_MISC_MEM, OPC_SYSTEM: begin
            dec.imm = i_imm;
         end
         default: begin
            dec.illegal = 1'b1;
         end
      endcase
      need    = '0;
      need.ld = dec.ctrl.mem_read_en;
      need.st = dec.ctrl.mem_write_en;
   end

endmodule

// File: rtl/superscalar_decode.sv
// WIDTH-lane registered decode stage. Decodes the fetch bundle, issues the
// longest in-order prefix that fits the free ROB/LDQ/STQ entries into the
// output register, and holds fetch until every valid lane has issued.
// XLEN must equal PKG_XLEN.
module superscalar_decode
   import superscalar_decode_pkg::*;
#(
   parameter int XLEN  = PKG_XLEN,
   parameter int WIDTH = 2,
   parameter int CNT_W = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    flush,
   input  logic                    fetch_valid,
   input  logic [WIDTH-1:0]        fetch_lane_valid,
   input  logic [WIDTH*32-1:0]     fetch_instr,
   input  logic [WIDTH*XLEN-1:0]   fetch_pc,
   output logic                    fetch_ready,
   input  logic [CNT_W-1:0]        rob_free,
   input  logic [CNT_W-1:0]        ldq_free,
   input  logic [CNT_W-1:0]        stq_free,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [WIDTH-1:0]        out_lane_valid,
   output logic [WIDTH*CTRL_W-1:0] out_ctrl,
   output logic [WIDTH*XLEN-1:0]   out_imm,
   output logic [WIDTH*XLEN-1:0]   out_pc,
   output logic [WIDTH-1:0]        out_illegal
);

   decode_lane_t            dec [WIDTH];
   res_need_t               need [WIDTH];
   logic [WIDTH-1:0]        is_load;
   logic [WIDTH-1:0]        is_store;
   logic [WIDTH-1:0]        lane_illegal;
   logic [WIDTH*CTRL_W-1:0] dec_ctrl_flat;
   logic [WIDTH*XLEN-1:0]   dec_imm_flat;
   logic [WIDTH*XLEN-1:0]   dec_pc_flat;

   logic [WIDTH-1:0]        issued_mask_reg, issued_mask_next;
   logic                    out_valid_reg;
   logic [WIDTH-1:0]        out_lane_valid_reg;
   logic [WIDTH*CTRL_W-1:0] out_ctrl_reg;
   logic [WIDTH*XLEN-1:0]   out_imm_reg;
   logic [WIDTH*XLEN-1:0]   out_pc_reg;
   logic [WIDTH-1:0]        out_illegal_reg;
   logic [CNT_W:0]          held_rob_reg, held_ldq_reg, held_stq_reg;

   logic [WIDTH-1:0]        remaining;
   logic [WIDTH-1:0]        sel_mask;
   logic [WIDTH-1:0]        issue_eff;
   logic                    stalled;
   logic                    can_load;
   logic                    load_en;
   logic [CNT_W:0]          rob_avail, ldq_avail, stq_avail;
   dec_state_t              state;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dec
         instruction_decode u_dec (
            .instr (fetch_instr[gi*32 +: 32]),
            .pc    (fetch_pc[gi*XLEN +: XLEN]),
            .dec   (dec[gi]),
            .need  (need[gi])
         );
         assign is_load[gi]                        = need[gi].ld;
         assign is_store[gi]                       = need[gi].st;
         assign lane_illegal[gi]                   = dec[gi].illegal;
         assign dec_ctrl_flat[gi*CTRL_W +: CTRL_W] = dec[gi].ctrl;
         assign dec_imm_flat[gi*XLEN +: XLEN]      = dec[gi].imm;
         assign dec_pc_flat[gi*XLEN +: XLEN]       = dec[gi].pc;
      end
   endgenerate

   // Free count less what the stalled output bundle still owes, floored at zero.
   function automatic logic [CNT_W:0] avail_of(input logic [CNT_W-1:0] free_cnt,
                                               input logic [CNT_W:0]   held,
                                               input logic             hold);
      logic [CNT_W:0] f;
      f = {1'b0, free_cnt};
      if (!hold) begin
         return f;
      end
      return (f >= held) ? (f - held) : '0;
   endfunction

   assign state     = (issued_mask_reg == '0) ? IDLE : PARTIAL;
   assign remaining = fetch_lane_valid & ~issued_mask_reg;
   assign stalled   = out_valid_reg && !out_ready;
   assign can_load  = !stalled;
   assign rob_avail = avail_of(rob_free, held_rob_reg, stalled);
   assign ldq_avail = avail_of(ldq_free, held_ldq_reg, stalled);
   assign stq_avail = avail_of(stq_free, held_stq_reg, stalled);

   decode_alloc_select #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
   ) u_select (
      .remaining  (remaining),
      .is_load    (is_load),
      .is_store   (is_store),
      .rob_avail  (rob_avail),
      .ldq_avail  (ldq_avail),
      .stq_avail  (stq_avail),
      .issue_mask (sel_mask)
   );

   assign issue_eff   = can_load ? sel_mask : '0;
   assign load_en     = fetch_valid && !flush && can_load && (|sel_mask);
   // Bundle is done when everything left issues now (trivially so for an empty bundle).
   assign fetch_ready = fetch_valid && !flush && (issue_eff == remaining);

   // Next issued_mask: clear on completion, flush or a dropped bundle, else accumulate.
   always_comb begin
      issued_mask_next = issued_mask_reg;
      if (flush || !fetch_valid || fetch_ready) begin
         issued_mask_next = '0;
      end else if (load_en) begin
         issued_mask_next = issued_mask_reg | sel_mask;
      end
   end

   // issued_mask state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issued_mask_reg <= '0;
      end else begin
         issued_mask_reg <= issued_mask_next;
      end
   end

   // Output pipeline register and the allocation it carries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg      <= 1'b0;
         out_lane_valid_reg <= '0;
         out_ctrl_reg       <= '0;
         out_imm_reg        <= '0;
         out_pc_reg         <= '0;
         out_illegal_reg    <= '0;
         held_rob_reg       <= '0;
         held_ldq_reg       <= '0;
         held_stq_reg       <= '0;
      end else if (flush || (!load_en && out_ready)) begin
         out_valid_reg      <= 1'b0;
         out_lane_valid_reg <= '0;
         out_illegal_reg    <= '0;
         held_rob_reg       <= '0;
         held_ldq_reg       <= '0;
         held_stq_reg       <= '0;
      end else if (load_en) begin
         out_valid_reg      <= 1'b1;
         out_lane_valid_reg <= sel_mask;
         out_ctrl_reg       <= dec_ctrl_flat;
         out_imm_reg        <= dec_imm_flat;
         out_pc_reg         <= dec_pc_flat;
         out_illegal_reg    <= lane_illegal & sel_mask;
         held_rob_reg       <= (CNT_W+1)'(popcount8(8'(sel_mask)));
         held_ldq_reg       <= (CNT_W+1)'(popcount8(8'(sel_mask & is_load)));
         held_stq_reg       <= (CNT_W+1)'(popcount8(8'(sel_mask & is_store)));
      end
   end

   assign out_valid      = out_valid_reg;
   assign out_lane_valid = out_lane_valid_reg;
   assign out_ctrl       = out_ctrl_reg;
   assign out_imm        = out_imm_reg;
   assign out_pc         = out_pc_reg;
   assign out_illegal    = out_illegal_reg;

   // A partially issued bundle must stay presented until it completes.
   a_hold_partial: assert property (@(posedge clk) disable iff (!rst_n || flush)
                                    (state == PARTIAL) |-> fetch_valid);

endmodule

// File: doc/superscalar_decode.md
# superscalar_decode

Registered, WIDTH-lane decode stage between the fetch buffer and rename/dispatch. Each cycle it decodes a fetch bundle of up to WIDTH instructions and checks them in program order against free ROB/LDQ/STQ entries. It issues the longest in-order prefix that fits into an output pipeline register with a valid/ready handshake. A bundle that does not fully fit is split across cycles, and the fetch side is held until every valid lane has issued.

## Interface
- XLEN, 32, datapath / immediate width
- WIDTH, 2, lanes per bundle (1..8)
- CNT_W, 6, width of free-count inputs
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash (mispredict/exception)
- fetch_valid  in  1  bundle present
- fetch_lane_valid  in  WIDTH  per-lane valid; may be non-contiguous
- fetch_instr  in  WIDTH×32  instructions
- fetch_pc  in  WIDTH×XLEN  lane PCs
- fetch_ready  out  1  bundle fully consumed this cycle
- rob_free, ldq_free, stq_free  in  CNT_W each  free entries, net of everything already dispatched
- out_valid  out  1  output bundle valid
- out_ready  in  1  dispatch accepts the output bundle
- out_lane_valid  out  WIDTH  lanes issued in this output bundle; lane positions are preserved, not compacted
- out_ctrl  out  WIDTH×control_signal_bus  decoded control signals
- out_imm  out  WIDTH×XLEN  immediates
- out_pc  out  WIDTH×XLEN  PCs
- out_illegal  out  WIDTH  opcode not recognised

## Operation
- Decode is combinational per lane and is captured in the output register.
- The output register loads when load_en = fetch_valid && !flush && (!out_valid || out_ready) && at least one lane is issued.
- State register issued_mask (WIDTH bits) records lanes of the current fetch bundle already issued.
  - IDLE: issued_mask == 0.
  - PARTIAL: issued_mask != 0.
- Remaining lanes: fetch_lane_valid & ~issued_mask.
- Resource availability in the current cycle is the free count minus the held bundle's allocation (out_rob_cnt, out_ldq_cnt, out_stq_cnt) when out_valid && !out_ready; otherwise it is the free count.
- Lane selection runs over remaining lanes in ascending index.
  - Each lane adds 1 ROB, plus 1 LDQ if it is a load, plus 1 STQ if it is a store.
  - Selection stops at the first lane whose cumulative need exceeds any availability.
  - Issued lanes form that in-order prefix.
- If every remaining lane is issued:
  - fetch_ready = 1.
  - issued_mask ← 0, giving IDLE.
- Otherwise:
  - fetch_ready = 0.
  - issued_mask |= newly issued lanes, giving PARTIAL.
- If no lane fits: no load, no state change. out_valid falls once the held bundle is consumed.
- Illegal opcodes:
  - out_illegal set.
  - rf_write_en and mem_write_en forced to 0.
  - Allocates a ROB entry only.
- Flush:
  - out_valid ← 0 and issued_mask ← 0.
  - fetch_ready = 0 in the flush cycle.
  - Flush overrides a simultaneous load.
- If out_valid && !out_ready, all out_* fields hold stable.
- If fetch_valid drops while in PARTIAL (protocol violation): assert in simulation; RTL returns to IDLE.

## Timing
- Latency: 1 cycle from fetch acceptance to out_valid. Throughput: one full bundle per cycle when resources allow.
- fetch_ready is combinational from fetch_valid, the free counts, out_ready and flush. No combinational path from fetch inputs to out_* fields.
- Reset (rst_n low, async):
  - out_valid, out_lane_valid, out_illegal = 0.
  - out_ctrl, out_imm, out_pc = 0.
  - Held counts = 0.
  - issued_mask = 0, giving IDLE.
- Count arithmetic is done at CNT_W+1 bits, so held counts never underflow availability.
- fetch_lane_valid == 0 with fetch_valid: fetch_ready = 1, no output load.

## Structure
- Shared package gets:
  - Opcode constants: LOAD, STORE, etc.
  - decode_lane_t: ctrl, imm, pc, illegal.
  - The WIDTH-independent resource-need typedef.
- The existing control_signal_bus stays in the package.
- Per-lane decode reuses the existing single-instruction instruction_decode, generated WIDTH times.
- One sub-module, decode_alloc_select: prefix-sum fit logic.
  - Inputs: remaining mask, per-lane load/store flags, three availabilities.
  - Output: issue mask.
- Top level holds the output register, held counts and issued_mask.

## Test plan
- WIDTH=2, both lanes ALU, rob_free=8, out_ready=1 → next cycle out_valid=1, out_lane_valid=2'b11, fetch_ready=1 in the issue cycle.
- Lanes {load, load}, ldq_free=1:
  - Cycle 0: lane0 issued, fetch_ready=0, PARTIAL.
  - Next cycle, with ldq_free=1: lane1 issued, fetch_ready=1.
- out_ready=0 held for 3 cycles with out_valid=1 → out_* stable, fetch_ready=0, held allocation subtracted (rob_free=2 with 2 held → no load).
- fetch_lane_valid=2'b10 → out_lane_valid=2'b10 and out_pc[1] = fetch_pc[1].
- Flush asserted in PARTIAL with load_en true → next cycle out_valid=0, issued_mask=0, fetch_ready=0 in the flush cycle.
- Instruction 0x0000007F (illegal) → out_illegal[0]=1, rf_write_en=0, rob consumption 1; rst_n pulsed low mid-PARTIAL → all outputs 0 immediately.
